alu_op_sequencer: RTL and testbench

//  Sequences one ALU instruction (8 functions, dest A or D) through the relay-timed ALU datapath:
//  - drives the function select to the datapath
//  - waits a fixed settle time
//  - captures the result and writes it to the destination register
//  - updates the condition flags

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_settle_timer.sv | 33 +++
 rtl/alu_op_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
//   alu_fn_e      : 3-bit ALU function codes driven to the datapath
//   seq_state_e   : sequencer FSM states
//   fn_sets_carry : true for the functions whose carry-out is meaningful
package alu_seq_pkg;

    localparam int unsigned ALU_W = 8;
    localparam int unsigned FN_W  = 3;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [FN_W-1:0] {
        FN_ADD = 3'b000,
        FN_INC = 3'b001,
        FN_AND = 3'b010,
        FN_OR  = 3'b011,
        FN_XOR = 3'b100,
        FN_NOT = 3'b101,
        FN_SHL = 3'b110,
        FN_CLR = 3'b111
    } alu_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SELECT = 2'b01,
        ST_SETTLE = 2'b10,
        ST_LATCH  = 2'b11
    } seq_state_e;

    // Arithmetic and shift functions produce a real carry; logic functions clear it.
    function automatic logic fn_sets_carry(input alu_fn_e fn);
        return (fn == FN_ADD) || (fn == FN_INC) || (fn == FN_SHL);
    endfunction

endpackage

// File: rtl/alu_seq_settle_timer.sv
// Loadable down-counter timing the datapath settle window.
//   clk, reset  : clock, synchronous active-high reset
//   load_i      : load load_val_i (has priority over en_i)
//   en_i        : decrement, saturating at zero
//   load_val_i  : value to load
//   zero_c_o    : combinational, count is zero
module alu_seq_settle_timer
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_c_o
);

    logic [CNT_W-1:0] count_q;

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_c_o = (count_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU instruction through the relay-timed datapath:
// select function, wait SETTLE_CYCLES, capture result, strobe the destination
// register write and update the condition flags.
//   clk, reset                 : clock, synchronous active-high reset
//   instr_valid / instr_ready  : instruction handshake (ready only in IDLE)
//   instr_fn, instr_dst        : function code and destination (0 = A, 1 = D)
//   alu_fn, alu_en             : datapath function select and enable
//   alu_result, alu_carry      : datapath outputs, sampled once settled
//   wr_a_en, wr_d_en, wr_data  : one-cycle register write strobes and data
//   flag_z, flag_s, flag_c     : condition flags
//   busy                       : sequencer not in IDLE
// Optional feature macro: ALU_SEQ_CARRY_FLAG_EN (carry flag register; when
// undefined flag_c is tied low and alu_carry is ignored).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [FN_W-1:0]  instr_fn,
    input  logic             instr_dst,
    output logic [FN_W-1:0]  alu_fn,
    output logic             alu_en,
    input  logic [ALU_W-1:0] alu_result,
    input  logic             alu_carry,
    output logic             wr_a_en,
    output logic             wr_d_en,
    output logic [ALU_W-1:0] wr_data,
    output logic             flag_z,
    output logic             flag_s,
    output logic             flag_c,
    output logic             busy
);

    // Settle window must fit the 4-bit timer and be at least one cycle
    if ((SETTLE_CYCLES == 0) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
        $fatal(1, "alu_op_sequencer: SETTLE_CYCLES must be 1..15");
    end

    seq_state_e       state_q;
    alu_fn_e          fn_q;
    logic             dst_q;
    logic             alu_en_q;
    logic             wr_a_q;
    logic             wr_d_q;
    logic [ALU_W-1:0] wr_data_q;
    logic             flag_z_q;
    logic             flag_s_q;
    logic             busy_q;
    logic             ready_q;

    logic             timer_load_c;
    logic             timer_en_c;
    logic             timer_zero_c;

    // Timer loads during SELECT so SETTLE lasts exactly SETTLE_CYCLES cycles
    assign timer_load_c = (state_q == ST_SELECT);
    assign timer_en_c   = (state_q == ST_SETTLE);

    alu_seq_settle_timer u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load_c),
        .en_i       (timer_en_c),
        .load_val_i (CNT_W'(SETTLE_CYCLES - 1)),
        .zero_c_o   (timer_zero_c)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            fn_q      <= FN_ADD;
            dst_q     <= 1'b0;
            alu_en_q  <= 1'b0;
            wr_a_q    <= 1'b0;
            wr_d_q    <= 1'b0;
            wr_data_q <= '0;
            flag_z_q  <= 1'b0;
            flag_s_q  <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            wr_a_q <= 1'b0;
            wr_d_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        fn_q     <= alu_fn_e'(instr_fn);
                        dst_q    <= instr_dst;
                        alu_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                        state_q  <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (timer_zero_c) begin
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    // Result is settled: capture, strobe, update flags; fn stays put
                    wr_data_q <= alu_result;
                    wr_a_q    <= ~dst_q;
                    wr_d_q    <= dst_q;
                    flag_z_q  <= (alu_result == '0);
                    flag_s_q  <= alu_result[ALU_W-1];
                    alu_en_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_CARRY_FLAG_EN
    logic flag_c_q;

    // Carry flag: datapath carry for arithmetic/shift, cleared for logic functions
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_c_q <= 1'b0;
        end else if (state_q == ST_LATCH) begin
            flag_c_q <= fn_sets_carry(fn_q) ? alu_carry : 1'b0;
        end
    end

    assign flag_c = flag_c_q;
`else
    logic unused_carry;

    assign unused_carry = alu_carry;
    assign flag_c       = 1'b0;
`endif

    assign instr_ready = ready_q;
    assign alu_fn      = fn_q;
    assign alu_en      = alu_en_q;
    assign wr_a_en     = wr_a_q;
    assign wr_d_en     = wr_d_q;
    assign wr_data     = wr_data_q;
    assign flag_z      = flag_z_q;
    assign flag_s      = flag_s_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: table-driven vectors, a mid-op
// reset sequence and randomized instructions against a behavioural model.
module tb_alu_op_sequencer;

    localparam int S = 4;
`ifdef ALU_SEQ_CARRY_FLAG_EN
    localparam logic C_EN = 1'b1;
`else
    localparam logic C_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_fn;
    logic       instr_dst;
    logic [2:0] alu_fn;
    logic       alu_en;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       wr_a_en;
    logic       wr_d_en;
    logic [7:0] wr_data;
    logic       flag_z;
    logic       flag_s;
    logic       flag_c;
    logic       busy;

    logic [7:0] opa;
    logic [7:0] opb;
    logic [8:0] dp;

    typedef struct {
        logic [2:0] fn;
        logic       dst;
        logic [7:0] a;
        logic [7:0] b;
        logic       chain;
        logic [7:0] data;
        logic       z;
        logic       s;
        logic       c;
    } op_t;

    int         total = 0;
    int         bad   = 0;
    logic [2:0] exp_flags;
    op_t        tbl[9];

    alu_op_sequencer #(
        .SETTLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_fn    (instr_fn),
        .instr_dst   (instr_dst),
        .alu_fn      (alu_fn),
        .alu_en      (alu_en),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .wr_a_en     (wr_a_en),
        .wr_d_en     (wr_d_en),
        .wr_data     (wr_data),
        .flag_z      (flag_z),
        .flag_s      (flag_s),
        .flag_c      (flag_c),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: {carry, result} from plain arithmetic
    function automatic logic [8:0] ref_alu(input logic [2:0] fn, input logic [7:0] a,
                                           input logic [7:0] b);
        case (fn)
            3'd0:    return 9'(a) + 9'(b);
            3'd1:    return 9'(a) + 9'd1;
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a[7], a[6:0], 1'b0};
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic is_arith(input logic [2:0] fn);
        return (fn == 3'd0) || (fn == 3'd1) || (fn == 3'd6);
    endfunction

    // Datapath stand-in: junk when disabled, carry forced high for logic ops
    always_comb begin
        dp = ref_alu(alu_fn, opa, opb);
        if (alu_en) begin
            alu_result = dp[7:0];
            alu_carry  = is_arith(alu_fn) ? dp[8] : 1'b1;
        end else begin
            alu_result = ~opb ^ 8'h3C;
            alu_carry  = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t rand_op();
        op_t        o;
        logic [8:0] r;
        o.fn    = 3'($urandom_range(0, 7));
        o.dst   = 1'($urandom_range(0, 1));
        o.a     = 8'($urandom);
        o.b     = ($urandom_range(0, 3) == 0) ? ~o.a : 8'($urandom);
        o.chain = 1'b0;
        r       = ref_alu(o.fn, o.a, o.b);
        o.data  = r[7:0];
        o.z     = (r[7:0] == 8'h00);
        o.s     = r[7];
        o.c     = is_arith(o.fn) & r[8];
        return o;
    endfunction

    function automatic logic [10:0] observe();
        return {alu_en, busy, instr_ready, wr_a_en, wr_d_en, alu_fn, flag_z, flag_s, flag_c};
    endfunction

    // One instruction: present, accept, then check every cycle through the write strobe
    task automatic run_op(input op_t cur, input logic chain, input op_t nxt, input logic imm);
        int          waited;
        logic        in_op;
        logic        done;
        logic [10:0] exp;
        logic [2:0]  new_flags;
        instr_valid = 1'b1;
        instr_fn    = cur.fn;
        instr_dst   = cur.dst;
        opa         = cur.a;
        opb         = cur.b;
        waited      = 0;
        while (!instr_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            check("accept_timeout", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        if (imm) check("accept_first_idle", 32'(waited), 32'd0);
        new_flags = {cur.z, cur.s, cur.c & C_EN};
        @(posedge clk);
        for (int k = 0; k <= S + 2; k++) begin
            @(negedge clk);
            in_op = (k <= S + 1);
            done  = (k == S + 2);
            exp   = {in_op, in_op, ~in_op, done & ~cur.dst, done & cur.dst, cur.fn,
                     done ? new_flags : exp_flags};
            check($sformatf("op fn=%0d dst=%0d k=%0d ctl", cur.fn, cur.dst, k),
                  32'(observe()), 32'(exp));
            if (done) check($sformatf("op fn=%0d wr_data", cur.fn), 32'(wr_data), 32'(cur.data));
            if (k <= S) begin
                instr_valid = 1'($urandom);
                instr_fn    = 3'($urandom);
                instr_dst   = 1'($urandom);
            end else if (k == S + 1) begin
                instr_valid = chain;
                instr_fn    = chain ? nxt.fn : 3'd0;
                instr_dst   = chain ? nxt.dst : 1'b0;
            end
        end
        exp_flags = new_flags;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        op_t  cur;
        op_t  nxt;
        logic prev_chain;
        logic ch;

        //         fn    dst   a      b      chain data   z     s     c
        tbl[0] = '{3'd2, 1'b0, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{3'd0, 1'b1, 8'hC0, 8'hC0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{3'd4, 1'b0, 8'hAA, 8'h55, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{3'd5, 1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{3'd1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{3'd3, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{3'd7, 1'b0, 8'h5A, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{3'd0, 1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{3'd6, 1'b1, 8'hC1, 8'h00, 1'b0, 8'h82, 1'b0, 1'b1, 1'b1};

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr_fn    = 3'd0;
        instr_dst   = 1'b0;
        opa         = 8'h00;
        opb         = 8'h00;
        exp_flags   = 3'b000;

        // Reset held three cycles, then released
        repeat (3) @(negedge clk);
        check("reset_held_ctl", 32'(observe()), 32'({5'b00100, 3'd0, 3'b000}));
        reset = 1'b0;
        @(negedge clk);
        check("reset_release_ctl", 32'(observe()), 32'({5'b00100, 3'd0, 3'b000}));
        check("reset_release_wr_data", 32'(wr_data), 32'd0);

        // Table-driven vectors, some chained with instr_valid held through LATCH
        prev_chain = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i], tbl[i].chain, tbl[(i < 8) ? i + 1 : i], prev_chain);
            prev_chain = tbl[i].chain;
        end

        // Reset while SETTLE counter reads 2
        instr_valid = 1'b1;
        instr_fn    = 3'd4;
        instr_dst   = 1'b1;
        opa         = 8'h81;
        opb         = 8'h00;
        check("midop_ready_before", 32'(instr_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midop_reset_ctl", 32'(observe()), 32'({5'b00100, 3'd0, 3'b000}));
        check("midop_reset_wr_data", 32'(wr_data), 32'd0);
        reset     = 1'b0;
        exp_flags = 3'b000;
        for (int j = 0; j < S + 4; j++) begin
            @(negedge clk);
            check($sformatf("midop_after_reset j=%0d", j), 32'(observe()),
                  32'({5'b00100, 3'd0, 3'b000}));
        end

        // Randomized instructions against the reference model
        cur        = rand_op();
        prev_chain = 1'b0;
        for (int i = 0; i < 25; i++) begin
            nxt = rand_op();
            ch  = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_op(cur, ch, nxt, prev_chain);
            prev_chain = ch;
            cur        = nxt;
        end

        instr_valid = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
